// File: rtl/psk4_symbol_source_if.sv
// Byte stream in, QPSK symbol stream and frame status out.
// master = byte producer / symbol consumer, slave = psk4_symbol_source.
interface psk4_symbol_source_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       s1;
  logic       s2;
  logic       sym_strobe;
  logic       frame_active;
  logic       frame_end;

  modport master (
    output in_data, in_valid,
    input  in_ready, s1, s2, sym_strobe, frame_active, frame_end
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, s1, s2, sym_strobe, frame_active, frame_end
  );
endinterface

// File: rtl/psk4_symbol_source.sv
// Byte-to-dibit QPSK symbol source: byte FIFO, preamble insertion, and one
// dibit per SYM_DIV clocks, MSB dibit first; idle symbol is (1,1).
//
//   state       | meaning
//   ST_IDLE     | no frame, emitting (1,1), waiting for a byte at a tick
//   ST_PREAMBLE | emitting PREAMBLE_SYMS alternating symbols (0,0),(1,1),...
//   ST_DATA     | emitting dibits of the current byte, refilling from FIFO
module psk4_symbol_source #(
  parameter int SYM_DIV       = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int PREAMBLE_SYMS = 8
) (
  input logic                 clk,
  input logic                 rst,
  psk4_symbol_source_if.slave bus
);
  localparam int CW = $clog2(SYM_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PREAMBLE_SYMS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_DATA} state_t;

  logic [CW-1:0] r_cnt;
  logic          w_tick;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  state_t        r_state, w_state_nxt;
  logic          r_s1, r_s2, w_s1_nxt, w_s2_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [PW-1:0] r_pre_cnt, w_pre_nxt;
  logic          w_frame_end_nxt;
  logic          r_sym_strobe, r_frame_active, r_frame_end;

  assign w_tick = (r_cnt == CW'(SYM_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign bus.in_ready = !w_full && !rst;
  assign w_push       = bus.in_valid && bus.in_ready;
  assign w_head       = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_s1_nxt        = r_s1;
    w_s2_nxt        = r_s2;
    w_shift_nxt     = r_shift;
    w_idx_nxt       = r_idx;
    w_pre_nxt       = r_pre_cnt;
    w_pop           = 1'b0;
    w_frame_end_nxt = 1'b0;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          {w_s1_nxt, w_s2_nxt} = 2'b11;
          if (!w_empty) begin
            w_state_nxt          = ST_PREAMBLE;
            {w_s1_nxt, w_s2_nxt} = 2'b00;
            w_pre_nxt            = PW'(1);
          end
        end
        ST_PREAMBLE: begin
          if (r_pre_cnt == PW'(PREAMBLE_SYMS)) begin
            w_pop                = 1'b1;
            w_state_nxt          = ST_DATA;
            {w_s1_nxt, w_s2_nxt} = w_head[7:6];
            w_shift_nxt          = {w_head[5:0], 2'b00};
            w_idx_nxt            = 2'd1;
          end else begin
            // Odd-numbered preamble symbols are (1,1), even ones (0,0).
            {w_s1_nxt, w_s2_nxt} = {2{r_pre_cnt[0]}};
            w_pre_nxt            = r_pre_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (r_idx == 2'd0) begin
            if (!w_empty) begin
              w_pop                = 1'b1;
              {w_s1_nxt, w_s2_nxt} = w_head[7:6];
              w_shift_nxt          = {w_head[5:0], 2'b00};
              w_idx_nxt            = 2'd1;
            end else begin
              w_state_nxt          = ST_IDLE;
              {w_s1_nxt, w_s2_nxt} = 2'b11;
              w_frame_end_nxt      = 1'b1;
            end
          end else begin
            {w_s1_nxt, w_s2_nxt} = r_shift[7:6];
            w_shift_nxt          = {r_shift[5:0], 2'b00};
            w_idx_nxt            = r_idx + 2'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_s1           <= 1'b1;
      r_s2           <= 1'b1;
      r_shift        <= '0;
      r_idx          <= '0;
      r_pre_cnt      <= '0;
      r_sym_strobe   <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_end    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_s1           <= w_s1_nxt;
      r_s2           <= w_s2_nxt;
      r_shift        <= w_shift_nxt;
      r_idx          <= w_idx_nxt;
      r_pre_cnt      <= w_pre_nxt;
      r_sym_strobe   <= w_tick;
      r_frame_active <= (w_state_nxt != ST_IDLE);
      r_frame_end    <= w_frame_end_nxt;
    end
  end

  assign bus.s1           = r_s1;
  assign bus.s2           = r_s2;
  assign bus.sym_strobe   = r_sym_strobe;
  assign bus.frame_active = r_frame_active;
  assign bus.frame_end    = r_frame_end;
endmodule

// File: tb/tb_psk4_symbol_source.sv
// Directed bench for psk4_symbol_source with SYM_DIV=4, PREAMBLE_SYMS=2, FIFO_DEPTH=4.
// Strobed symbols of active frames are logged as {s1,s2,frame_active,frame_end}.
module tb_psk4_symbol_source;
  localparam int SYM_DIV = 4;
  localparam int PRE     = 2;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic rst;
  psk4_symbol_source_if bus ();

  psk4_symbol_source #(
    .SYM_DIV      (SYM_DIV),
    .FIFO_DEPTH   (DEPTH),
    .PREAMBLE_SYMS(PRE)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] q[$];
  logic [3:0] exp_q[$];
  int         fe_cnt = 0, n_strobe = 0, gap_err = 0, chg_err = 0, idle_bad = 0;
  int         gap = 0;
  logic       have_prev = 1'b0;
  logic [1:0] prev_sym = 2'b11;
  time        acc_t[16];
  int         n_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Symbol monitor: hold/spacing of symbols, idle value, and frame log.
  always @(negedge clk) begin
    if (rst) begin
      have_prev <= 1'b0;
      prev_sym  <= {bus.s1, bus.s2};
      gap       <= 0;
    end else begin
      prev_sym <= {bus.s1, bus.s2};
      if (({bus.s1, bus.s2} != prev_sym) && !bus.sym_strobe) chg_err <= chg_err + 1;
      if (!bus.frame_active && ({bus.s1, bus.s2} != 2'b11)) idle_bad <= idle_bad + 1;
      if (bus.sym_strobe) begin
        if (have_prev && gap != SYM_DIV) gap_err <= gap_err + 1;
        have_prev <= 1'b1;
        gap       <= 1;
        n_strobe  <= n_strobe + 1;
        if (bus.frame_active || bus.frame_end)
          q.push_back({bus.s1, bus.s2, bus.frame_active, bus.frame_end});
        if (bus.frame_end) fe_cnt <= fe_cnt + 1;
      end else begin
        gap <= gap + 1;
      end
    end
  end

  task automatic push(input logic [7:0] b, input bit keep);
    int t;
    t = 0;
    @(negedge clk);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("push_accept", 32'(t < 200), 1);
    @(posedge clk);
    acc_t[n_acc] = $time;
    n_acc++;
    #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_fe(input string tag, input int target, input int budget);
    int t;
    t = 0;
    while (fe_cnt < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, 32'(fe_cnt >= target), 1);
  endtask

  task automatic cmp_frames(input string tag);
    check({tag, "_len"}, q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), q[i], exp_q[i]);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int d = 3; d >= 0; d--) exp_q.push_back({b[2*d+1], b[2*d], 2'b10});
  endtask

  initial begin
    int base_fe, base_st;
    logic [7:0] bp_bytes [6];
    bp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    // 1: reset values and idle strobing
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1;
    check("rst_s1", bus.s1, 1);
    check("rst_s2", bus.s2, 1);
    check("rst_ready", bus.in_ready, 0);
    check("rst_active", bus.frame_active, 0);
    check("rst_strobe", bus.sym_strobe, 0);
    check("rst_fend", bus.frame_end, 0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1 check("rel_ready", bus.in_ready, 1);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ready", bus.in_ready, 0);
    check("mid_rst_s", {bus.s1, bus.s2}, 2'b11);
    check("mid_rst_active", bus.frame_active, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    base_st = n_strobe;
    repeat (40) @(negedge clk);
    #1 check("idle_strobes", n_strobe - base_st, 10);
    check("idle_ready", bus.in_ready, 1);

    // 2: single byte 0xB4
    q.delete();
    base_fe = fe_cnt;
    push(8'hB4, 0);
    wait_fe("single_done", base_fe + 1, 200);
    repeat (20) @(negedge clk);
    exp_q = '{4'b0010, 4'b1110, 4'b1010, 4'b1110, 4'b0110, 4'b0010, 4'b1101};
    cmp_frames("single");

    // 3: back-to-back 0xFF, 0x00 in one frame
    q.delete();
    base_fe = fe_cnt;
    push(8'hFF, 0);
    push(8'h00, 0);
    wait_fe("b2b_done", base_fe + 1, 300);
    repeat (40) @(negedge clk);
    check("b2b_fe_count", fe_cnt - base_fe, 1);
    exp_q = '{4'b0010, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110,
              4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1101};
    cmp_frames("b2b");

    // 4: backpressure with valid held high
    q.delete();
    base_fe = fe_cnt;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push(bp_bytes[i], i < 5);
      if (i == 3) check("bp_ready_full", bus.in_ready, 0);
    end
    check("bp_accept_gap", 32'((acc_t[5] - acc_t[4]) / 10), 16);
    wait_fe("bp_done", base_fe + 1, 400);
    repeat (10) @(negedge clk);
    exp_q = '{4'b0010, 4'b1110};
    for (int i = 0; i < 6; i++) add_byte(bp_bytes[i]);
    exp_q.push_back(4'b1101);
    cmp_frames("bp");

    // 5: underrun, second byte gets its own preamble
    q.delete();
    base_fe = fe_cnt;
    push(8'h1B, 0);
    wait_fe("ur_a_done", base_fe + 1, 200);
    repeat (40) @(negedge clk);
    push(8'hE4, 0);
    wait_fe("ur_b_done", base_fe + 2, 200);
    repeat (10) @(negedge clk);
    exp_q = '{4'b0010, 4'b1110, 4'b0010, 4'b0110, 4'b1010, 4'b1110, 4'b1101,
              4'b0010, 4'b1110, 4'b1110, 4'b1010, 4'b0110, 4'b0010, 4'b1101};
    cmp_frames("ur");

    // 6: reset during 2nd data dibit with 2 bytes queued
    q.delete();
    base_fe = fe_cnt;
    push(8'h5A, 0);
    push(8'hC3, 0);
    push(8'h3C, 0);
    begin
      int t;
      t = 0;
      while (q.size() < 4 && t < 200) begin
        @(negedge clk);
        t++;
      end
      check("mf_reached", 32'(q.size() >= 4), 1);
    end
    check("mf_pre_rst_sym", q[3], 4'b0110);
    #2 rst = 1'b1;
    #1;
    check("mf_rst_s", {bus.s1, bus.s2}, 2'b11);
    check("mf_rst_active", bus.frame_active, 0);
    check("mf_rst_ready", bus.in_ready, 0);
    check("mf_rst_fend", bus.frame_end, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    q.delete();
    repeat (60) @(negedge clk);
    check("mf_nothing_emitted", q.size(), 0);
    check("mf_no_fend", fe_cnt - base_fe, 0);
    check("mf_ready", bus.in_ready, 1);

    check("sym_spacing", gap_err, 0);
    check("sym_hold", chg_err, 0);
    check("idle_value", idle_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/psk4_symbol_source.md
# psk4_symbol_source

Byte-to-dibit symbol source that drives the `s1`/`s2` inputs of the QPSK (PSK4) modulator.
- Accepts bytes over a valid/ready handshake and buffers them in a small FIFO.
- Prepends a fixed preamble to each frame.
- Emits one dibit per symbol period, derived from a clock divider.
- Holds the idle symbol (1,1) whenever no frame is active.

## Interface

Parameters:
- `SYM_DIV`, 16: clk cycles per symbol; legal range ≥ 2.
- `FIFO_DEPTH`, 4: byte FIFO entries; must be a power of 2, ≥ 2.
- `PREAMBLE_SYMS`, 8: preamble length in symbols; legal range ≥ 1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  payload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  FIFO can accept a byte.
- `s1`  out  1  in-phase symbol bit, to modulator `s1`.
- `s2`  out  1  quadrature symbol bit, to modulator `s2`.
- `sym_strobe`  out  1  one-cycle pulse, first cycle of each new symbol.
- `frame_active`  out  1  high in PREAMBLE or DATA.
- `frame_end`  out  1  one-cycle pulse when DATA returns to IDLE.

## Operation

- **Symbol tick:** a free-running counter counts 0..`SYM_DIV`-1 and wraps. A tick is the cycle where count == `SYM_DIV`-1. All `s1`/`s2`/state updates occur on the clock edge ending a tick cycle.
- **FIFO:**
  - Write occurs when `in_valid && in_ready`.
  - `in_ready` = !full, and is forced low while `rst` is high.
  - A push and a pop in the same cycle both take effect; occupancy is unchanged.
  - Pops happen only at ticks.
- **Dibit order:** MSB first. Byte b produces (s1,s2) = (b[7],b[6]), (b[5],b[4]), (b[3],b[2]), (b[1],b[0]).
- **State machine** (three states; a 2-bit dibit index; an 8-bit shift register):
  - **IDLE:**
    - Output (1,1).
    - At a tick with the FIFO non-empty: go to PREAMBLE and emit the first preamble symbol.
  - **PREAMBLE:**
    - Emits `PREAMBLE_SYMS` symbols alternating (0,0),(1,1),(0,0),…, starting with (0,0).
    - At the tick after the last preamble symbol: pop a byte, go to DATA, emit its first dibit. The FIFO is guaranteed non-empty here, because nothing else pops.
  - **DATA:**
    - Each tick emits the next dibit.
    - At a tick where all 4 dibits of the current byte have been emitted:
      - FIFO non-empty: pop the next byte and emit its first dibit with no gap.
      - FIFO empty: go to IDLE, emit (1,1), pulse `frame_end`.
    - A byte arriving later starts a new frame, including a new preamble.
- **Status outputs:**
  - `sym_strobe` is registered. It is high in the cycle after each tick edge where `s1`/`s2` were loaded, in every state, IDLE included.
  - `frame_active` is registered and high in PREAMBLE and DATA.
- **Reset values:**
  - `s1`=1, `s2`=1.
  - `sym_strobe`=0, `frame_active`=0, `frame_end`=0, `in_ready`=0.
  - FIFO empty, counter 0, state IDLE.
- **Reset mid-frame:** asynchronous. The FIFO and the current byte are discarded and outputs take their reset values immediately. No `frame_end` pulse is generated.

## Timing

- **Symbol period:** `s1`/`s2` are stable for exactly `SYM_DIV` cycles and change only on tick edges.
- **First tick after reset:** the first tick edge comes `SYM_DIV` cycles after `rst` deasserts.
- **Start-of-frame latency:**
  - A byte accepted while IDLE waits for the next tick edge; that edge starts the preamble.
  - The first data dibit appears `PREAMBLE_SYMS` symbol periods after the preamble starts.
- **Continuous streaming:** throughput is 1 byte per 4·`SYM_DIV` cycles. A byte written before the tick on which it is needed causes no idle gap.
- **`in_ready` after pop:** rises the cycle after a pop frees a full FIFO.

## Test plan

Unless stated otherwise, tests use `SYM_DIV`=4, `PREAMBLE_SYMS`=2, `FIFO_DEPTH`=4.

1. **Reset values:** assert `rst` mid-cycle -> immediately `s1`=`s2`=1, `in_ready`=0, `frame_active`=0. Release -> `in_ready`=1, and `sym_strobe` pulses every 4 cycles with (1,1) held.
2. **Single byte:** write 0xB4 -> symbols (0,0),(1,1),(1,0),(1,1),(0,1),(0,0), then (1,1) with a `frame_end` pulse. Each symbol lasts exactly 4 cycles and `frame_active` covers the 6 symbols.
3. **Back-to-back bytes:** write 0xFF then 0x00 -> preamble, then four (1,1) and four (0,0) with no idle symbol between the bytes, and a single `frame_end`.
4. **Backpressure:** hold `in_valid`=1 with 6 bytes -> `in_ready` drops after the 4th accept. Accepts resume one per 16 cycles. All 6 bytes are emitted in order with no loss or duplication.
5. **Underrun:** write byte A, then write byte B 40 cycles after A's last dibit -> A's frame ends with `frame_end`, then B gets a fresh preamble.
6. **Reset mid-frame:** assert `rst` during the 2nd data dibit with 2 bytes queued -> outputs go to (1,1) immediately. After release, nothing is emitted until new bytes are written.
